// File: rtl/cbus_pkg.sv
// cbus_pkg -- shared CBus request/response types.
//   cbus_req_t  : requester -> bus (valid, direction, size, address, strobe, write data, burst length in beats)
//   cbus_resp_t : bus -> requester (ready per beat, last beat marker, read data)
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter -- N-channel round-robin CBus arbiter with burst lock.
//
// Multiplexes NUM_CH converter requests onto one external CBus port. An idle
// cycle picks the first valid channel at or after the round-robin pointer; the
// winner then owns the bus until its last beat (or until it drops valid), after
// which the pointer moves just past it.
//
// Ports:
//   clk     in   core clock
//   resetn  in   asynchronous active-low reset
//   ireqs   in   per-channel requests   (cbus_req_t  x NUM_CH)
//   iresps  out  per-channel responses  (cbus_resp_t x NUM_CH)
//   oreq    out  request to the external bus
//   oresp   in   response from the external bus
//
// Optional feature macro: CBUS_ARB_ADDR_XLAT_EN
//   When defined, a granted address in kseg0/kseg1 (addr[31:30] == 2'b10) is
//   folded to its physical alias by clearing addr[31:29]. When undefined the
//   address passes through unchanged.
module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  cbus_req_t  [NUM_CH-1:0]  ireqs,
  output cbus_resp_t [NUM_CH-1:0]  iresps,
  output cbus_req_t                oreq,
  input  cbus_resp_t               oresp
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e           state_r;
  state_e           state_nxt_s;
  logic [IDX_W-1:0] sel_r;
  logic [IDX_W-1:0] sel_nxt_s;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] rr_ptr_nxt_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             win_found_s;

  // Channel index base+off, wrapped modulo NUM_CH (NUM_CH=1 always yields 0).
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = (int'(base) + off) % NUM_CH;
    return IDX_W'(sum);
  endfunction

  // Round-robin scan from the registered pointer; only registered state and
  // request valids feed the decision, never the external response.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      win_idx_s   = (ireqs[wrap_add(rr_ptr_r, i)].valid && !win_found_s)
                    ? wrap_add(rr_ptr_r, i) : win_idx_s;
      win_found_s = win_found_s | ireqs[wrap_add(rr_ptr_r, i)].valid;
    end
  end

  // Next-state decode and request/response steering.
  always_comb begin
    state_nxt_s  = state_r;
    sel_nxt_s    = sel_r;
    rr_ptr_nxt_s = rr_ptr_r;
    oreq         = '0;
    iresps       = '0;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          state_nxt_s = ST_BUSY;
          sel_nxt_s   = win_idx_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Pass-through: a dropped valid shows up as oreq.valid=0 on its own.
        oreq = ireqs[sel_r];
`ifdef CBUS_ARB_ADDR_XLAT_EN
        if (ireqs[sel_r].addr[31:30] == 2'b10) begin
          oreq.addr[31:29] = 3'b000;
        end else begin
          oreq.addr = ireqs[sel_r].addr;
        end
`endif
        iresps[sel_r] = oresp;
        // Burst ends on the last accepted beat, or early if the owner
        // abandons it; either way the pointer moves past the owner.
        if (!ireqs[sel_r].valid || (oresp.ready && oresp.last)) begin
          state_nxt_s  = ST_IDLE;
          rr_ptr_nxt_s = wrap_add(sel_r, 32'sd1);
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, grant index and round-robin pointer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= ST_IDLE;
      sel_r    <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      sel_r    <= sel_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter -- self-checking bench for cbus_rr_arbiter (NUM_CH=4).
// The stimulus thread plays the requesters and a simple always-ready memory,
// and queues each expected bus beat (cycle, owning channel, address). A monitor
// pops one entry for every accepted beat on the external port.
module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  localparam int NUM_CH = 4;

  localparam logic [31:0] A0 = 32'h8000_1000;
  localparam logic [31:0] A1 = 32'h4000_0000;
  localparam logic [31:0] A2 = 32'hBFC0_0000;
  localparam logic [31:0] A3 = 32'hC000_0000;
`ifdef CBUS_ARB_ADDR_XLAT_EN
  localparam logic [31:0] E0 = 32'h0000_1000;
  localparam logic [31:0] E2 = 32'h1FC0_0000;
`else
  localparam logic [31:0] E0 = 32'h8000_1000;
  localparam logic [31:0] E2 = 32'hBFC0_0000;
`endif
  localparam logic [31:0] E1 = 32'h4000_0000;
  localparam logic [31:0] E3 = 32'hC000_0000;

  logic                     clk = 1'b0;
  logic                     resetn;
  cbus_req_t  [NUM_CH-1:0]  ireqs;
  cbus_resp_t [NUM_CH-1:0]  iresps;
  cbus_req_t                oreq;
  cbus_resp_t               oresp;

  cbus_rr_arbiter #(.NUM_CH(NUM_CH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .ireqs  (ireqs),
    .iresps (iresps),
    .oreq   (oreq),
    .oresp  (oresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          ch;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   beat_cnt = 0;
  int   ch_beats [NUM_CH];
  int   drop_at  [NUM_CH];
  bit   hold     [NUM_CH];
  bit   pend_drop[NUM_CH];
  bit   hs_prev      = 1'b0;
  bit   hs_last_prev = 1'b0;
  int   hs_ch_prev   = -1;
  int   t0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Channel whose response carries ready; -1 none, -2 more than one.
  function automatic int granted_ch();
    int g = -1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (iresps[c].ready) begin
        if (g == -1) g = c;
        else g = -2;
      end
    end
    return g;
  endfunction

  task automatic expect_beat(input int at, input int c, input logic [31:0] a);
    exp_t e;
    e.cyc  = at;
    e.ch   = c;
    e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic raise(input int c, input logic [31:0] a, input int len, input bit h, input bit wr);
    ireqs[c]          = '0;
    ireqs[c].valid    = 1'b1;
    ireqs[c].is_write = wr;
    ireqs[c].size     = 3'd2;
    ireqs[c].addr     = a;
    ireqs[c].strobe   = wr ? 4'hF : 4'h0;
    ireqs[c].data     = 32'hC0DE_0000 | 32'(c);
    ireqs[c].len      = 8'(len);
    hold[c]           = h;
    ch_beats[c]       = 0;
  endtask

  // One clock: requester updates at +1, memory response at +2, completion
  // bookkeeping at +3; the monitor samples at the falling edge (+5).
  task automatic cycle();
    @(posedge clk);
    cyc++;
    if (hs_prev) begin
      if (hs_last_prev) beat_cnt = 0;
      else beat_cnt++;
      if (hs_ch_prev >= 0) ch_beats[hs_ch_prev]++;
    end
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pend_drop[c]) begin
        ireqs[c].valid = 1'b0;
        pend_drop[c]   = 1'b0;
      end
      if (drop_at[c] >= 0 && ch_beats[c] == drop_at[c] && ireqs[c].valid) begin
        ireqs[c].valid = 1'b0;
        drop_at[c]     = -1;
      end
    end
    #1;
    if (oreq.valid) begin
      oresp.ready = 1'b1;
      oresp.last  = (beat_cnt == int'(oreq.len) - 1);
      oresp.data  = 32'(cyc);
    end else begin
      oresp    = '0;
      beat_cnt = 0;
    end
    #1;
    hs_prev      = oresp.ready;
    hs_last_prev = oresp.last;
    hs_ch_prev   = -1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (iresps[c].ready) begin
        hs_ch_prev = c;
        if (iresps[c].last && !hold[c]) pend_drop[c] = 1'b1;
      end
    end
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Monitor: every accepted beat on the external port must match the queue head.
  initial begin
    exp_t e;
    int   g;
    forever begin
      @(negedge clk);
      if (oreq.valid && oresp.ready) begin
        g = granted_ch();
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: cycle %0d channel %0d addr 0x%0h, expected no beat", cyc, g, oreq.addr);
        end else begin
          e = exp_q.pop_front();
          check("beat_cycle", 64'(cyc), 64'(e.cyc));
          check("beat_channel", 64'(g), 64'(e.ch));
          check("beat_addr", 64'(oreq.addr), 64'(e.addr));
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    resetn = 1'b0;
    ireqs  = '0;
    oresp  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_beats[c]  = 0;
      drop_at[c]   = -1;
      hold[c]      = 1'b0;
      pend_drop[c] = 1'b0;
    end

    // Reset state.
    cycles(3);
    check("rst_oreq_valid", 64'(oreq.valid), 64'(0));
    check("rst_iresps_zero", 64'(|iresps), 64'(0));
    resetn = 1'b1;
    cycles(2);

    // Single 4-beat read on ch2: first beat one cycle after valid.
    t0 = cyc;
    raise(2, A2, 4, 1'b0, 1'b0);
    for (int b = 1; b <= 4; b++) expect_beat(t0 + b, 2, E2);
    cycles(5);
    check("single_idle_after_last", 64'(oreq.valid), 64'(0));
    cycles(2);

    // Reset in the middle of an 8-beat write on ch0.
    t0 = cyc;
    raise(0, A0, 8, 1'b0, 1'b1);
    expect_beat(t0 + 1, 0, E0);
    expect_beat(t0 + 2, 0, E0);
    cycles(2);
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("rst_mid_oreq_valid", 64'(oreq.valid), 64'(0));
    check("rst_mid_iresps_zero", 64'(|iresps), 64'(0));
    ireqs[0] = '0;
    oresp    = '0;
    cycles(2);
    resetn = 1'b1;
    cycle();

    // Fairness: all channels valid, 1-beat bursts -> 0,1,2,3,0 with idle gaps.
    t0 = cyc;
    raise(0, A0, 1, 1'b1, 1'b0);
    raise(1, A1, 1, 1'b1, 1'b0);
    raise(2, A2, 1, 1'b1, 1'b0);
    raise(3, A3, 1, 1'b1, 1'b0);
    expect_beat(t0 + 1, 0, E0);
    expect_beat(t0 + 3, 1, E1);
    expect_beat(t0 + 5, 2, E2);
    expect_beat(t0 + 7, 3, E3);
    expect_beat(t0 + 9, 0, E0);
    cycles(10);
    for (int c = 0; c < NUM_CH; c++) begin
      ireqs[c].valid = 1'b0;
      hold[c]        = 1'b0;
    end
    cycle();

    // Burst lock: ch1 arrives mid-burst and waits for ch0's last beat.
    t0 = cyc;
    raise(0, A0, 8, 1'b0, 1'b1);
    for (int b = 1; b <= 8; b++) expect_beat(t0 + b, 0, E0);
    cycles(3);
    raise(1, A1, 2, 1'b0, 1'b0);
    expect_beat(t0 + 10, 1, E1);
    expect_beat(t0 + 11, 1, E1);
    cycles(9);
    check("lock_idle_after_ch1", 64'(oreq.valid), 64'(0));
    cycle();

    // Valid drop: ch1 abandons a 4-beat burst at beat 2; ch2 goes next, then ch0.
    t0 = cyc;
    raise(1, A1, 4, 1'b0, 1'b0);
    drop_at[1] = 2;
    expect_beat(t0 + 1, 1, E1);
    expect_beat(t0 + 2, 1, E1);
    cycle();
    raise(2, A2, 1, 1'b0, 1'b0);
    raise(0, A0, 1, 1'b0, 1'b0);
    expect_beat(t0 + 5, 2, E2);
    expect_beat(t0 + 7, 0, E0);
    cycles(2);
    check("drop_oreq_valid", 64'(oreq.valid), 64'(0));
    cycles(5);

    // Lone requester ch3 is regranted after each one-cycle idle gap.
    t0 = cyc;
    raise(3, A3, 1, 1'b1, 1'b0);
    expect_beat(t0 + 1, 3, E3);
    expect_beat(t0 + 3, 3, E3);
    expect_beat(t0 + 5, 3, E3);
    cycles(6);
    ireqs[3].valid = 1'b0;
    hold[3]        = 1'b0;
    cycles(3);

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
